// File: rtl/dense_layer_scheduler.sv
// Dense-layer scheduler: steps one shared MAC through a fully connected layer.
// Define DENSE_SCHED_PERF_EN to add the perf_cycles / perf_stall counters.
module dense_layer_scheduler #(
  parameter int MAX_IN  = 784,
  parameter int MAX_OUT = 128,
  parameter int DATA_W  = 16,
  parameter int FRAC_W  = 8,
  parameter int ACC_W   = 40,
  parameter int RD_LAT  = 2
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              start,
  input  logic                              abort,
  input  logic [$clog2(MAX_IN+1)-1:0]       cfg_in_len,
  input  logic [$clog2(MAX_OUT+1)-1:0]      cfg_out_len,
  input  logic                              cfg_relu,
  output logic                              busy,
  output logic                              done,
  output logic                              cfg_err,
  output logic [$clog2(MAX_IN)-1:0]         feat_addr,
  output logic [$clog2(MAX_IN*MAX_OUT)-1:0] wgt_addr,
  output logic [$clog2(MAX_OUT)-1:0]        bias_addr,
  output logic                              rd_en,
  input  logic [DATA_W-1:0]                 feat_rdata,
  input  logic [DATA_W-1:0]                 wgt_rdata,
  input  logic [DATA_W-1:0]                 bias_rdata,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_W-1:0]                 out_data,
  output logic [$clog2(MAX_OUT)-1:0]        out_index
`ifdef DENSE_SCHED_PERF_EN
  ,
  output logic [31:0]                       perf_cycles,
  output logic [31:0]                       perf_stall
`endif
);

  localparam int IN_LW   = $clog2(MAX_IN+1);
  localparam int OUT_LW  = $clog2(MAX_OUT+1);
  localparam int FEAT_AW = $clog2(MAX_IN);
  localparam int WGT_AW  = $clog2(MAX_IN*MAX_OUT);
  localparam int BIAS_AW = $clog2(MAX_OUT);

  localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_BIAS, S_MAC, S_DRAIN, S_EMIT, S_DONE} state_t;

  state_t state_q, state_d;
  logic   ld_cfg, err_d, emit_load, last_rd, last_out, cfg_ok, more_pending;

  logic [IN_LW-1:0]   in_len_q;
  logic [OUT_LW-1:0]  out_len_q;
  logic               relu_q;
  logic [FEAT_AW-1:0] i_q;
  logic [BIAS_AW-1:0] o_q;
  logic [WGT_AW-1:0]  base_q;

  logic [RD_LAT-1:0] vld_p;
  logic [RD_LAT-1:0] is_bias_p;

  logic signed [DATA_W-1:0]   feat_s, wgt_s, bias_s;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_q, acc_d;

  function automatic logic signed [DATA_W-1:0] rescale_sat(input logic signed [ACC_W-1:0] a,
                                                           input logic relu);
    logic signed [ACC_W-1:0]  r;
    logic signed [DATA_W-1:0] y;
    r = a >>> FRAC_W;
    if (r > SAT_HI)      y = SAT_HI[DATA_W-1:0];
    else if (r < SAT_LO) y = SAT_LO[DATA_W-1:0];
    else                 y = r[DATA_W-1:0];
    if (relu && y[DATA_W-1]) y = '0;
    return y;
  endfunction

  assign cfg_ok   = (cfg_in_len != '0) && (cfg_in_len <= IN_LW'(MAX_IN)) &&
                    (cfg_out_len != '0) && (cfg_out_len <= OUT_LW'(MAX_OUT));
  assign last_rd  = (i_q == FEAT_AW'(in_len_q - 1'b1));
  assign last_out = (OUT_LW'(o_q) == out_len_q - 1'b1);

  assign rd_en     = (state_q == S_BIAS) || (state_q == S_MAC);
  assign out_valid = (state_q == S_EMIT);
  assign done      = (state_q == S_DONE);
  assign busy      = (state_q == S_BIAS) || (state_q == S_MAC) ||
                     (state_q == S_DRAIN) || (state_q == S_EMIT);
  assign feat_addr = i_q;
  assign wgt_addr  = base_q + WGT_AW'(i_q);
  assign bias_addr = o_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ld_cfg  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE:  if (start) begin
                 if (cfg_ok) begin
                   state_d = S_BIAS;
                   ld_cfg  = 1'b1;
                 end else begin
                   err_d = 1'b1;
                 end
               end
      S_BIAS:  state_d = S_MAC;
      S_MAC:   if (last_rd) state_d = S_DRAIN;
      S_DRAIN: if (!more_pending) state_d = S_EMIT;
      S_EMIT:  if (out_ready) state_d = last_out ? S_DONE : S_BIAS;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      ld_cfg  = 1'b0;
      err_d   = 1'b0;
    end
    emit_load = (state_q == S_DRAIN) && (state_d == S_EMIT);
  end

  // Drain may leave once only the return being consumed this cycle is still in flight.
  always_comb begin
    more_pending = 1'b0;
    for (int k = 0; k < RD_LAT-1; k++) more_pending = more_pending | vld_p[k];
  end

  assign feat_s = signed'(feat_rdata);
  assign wgt_s  = signed'(wgt_rdata);
  assign bias_s = signed'(bias_rdata);
  assign prod   = feat_s * wgt_s;

  always_comb begin
    acc_d = acc_q;
    if (vld_p[RD_LAT-1]) begin
      if (is_bias_p[RD_LAT-1])
        acc_d = signed'({{(ACC_W-DATA_W-FRAC_W){bias_s[DATA_W-1]}}, bias_s, {FRAC_W{1'b0}}});
      else
        acc_d = acc_q + signed'({{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod});
    end
  end

  // stage p0..p(RD_LAT-1): read tags track memory returns; result captured on EMIT entry
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_p     <= '0;
      is_bias_p <= '0;
      acc_q     <= '0;
      cfg_err   <= 1'b0;
      in_len_q  <= '0;
      out_len_q <= '0;
      relu_q    <= 1'b0;
      i_q       <= '0;
      o_q       <= '0;
      base_q    <= '0;
      out_data  <= '0;
      out_index <= '0;
    end else begin
      cfg_err <= err_d;
      acc_q   <= acc_d;
      if (abort) begin
        vld_p     <= '0;
        is_bias_p <= '0;
      end else begin
        vld_p[0]     <= rd_en;
        is_bias_p[0] <= (state_q == S_BIAS);
        for (int k = 1; k < RD_LAT; k++) begin
          vld_p[k]     <= vld_p[k-1];
          is_bias_p[k] <= is_bias_p[k-1];
        end
      end
      if (ld_cfg) begin
        in_len_q  <= cfg_in_len;
        out_len_q <= cfg_out_len;
        relu_q    <= cfg_relu;
        i_q       <= '0;
        o_q       <= '0;
        base_q    <= '0;
      end else if (abort) begin
        i_q    <= '0;
        o_q    <= '0;
        base_q <= '0;
      end else if (state_q == S_MAC) begin
        i_q <= last_rd ? '0 : i_q + 1'b1;
      end else if (state_q == S_EMIT && out_ready && !last_out) begin
        o_q    <= o_q + 1'b1;
        base_q <= base_q + WGT_AW'(in_len_q);
      end
      if (emit_load) begin
        out_data  <= rescale_sat(acc_d, relu_q);
        out_index <= o_q;
      end
    end
  end

`ifdef DENSE_SCHED_PERF_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else if (ld_cfg) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else begin
      if (busy && perf_cycles != '1) perf_cycles <= perf_cycles + 1'b1;
      if (state_q == S_EMIT && !out_ready && perf_stall != '1) perf_stall <= perf_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dense_layer_scheduler.sv
// Bench for dense_layer_scheduler: fixed vectors, randomized layers, error/abort corners.
`timescale 1ns/1ps
module tb_dense_layer_scheduler;
  localparam int MAX_IN  = 784;
  localparam int MAX_OUT = 128;
  localparam int DATA_W  = 16;
  localparam int RD_LAT  = 2;
  localparam int IN_LW   = $clog2(MAX_IN+1);
  localparam int OUT_LW  = $clog2(MAX_OUT+1);
  localparam int FEAT_AW = $clog2(MAX_IN);
  localparam int WGT_AW  = $clog2(MAX_IN*MAX_OUT);
  localparam int BIAS_AW = $clog2(MAX_OUT);

  logic clock, reset_n, start, abort, cfg_relu;
  logic [IN_LW-1:0]   cfg_in_len;
  logic [OUT_LW-1:0]  cfg_out_len;
  logic busy, done, cfg_err, rd_en, out_valid, out_ready;
  logic [FEAT_AW-1:0] feat_addr;
  logic [WGT_AW-1:0]  wgt_addr;
  logic [BIAS_AW-1:0] bias_addr;
  logic [DATA_W-1:0]  feat_rdata, wgt_rdata, bias_rdata, out_data;
  logic [BIAS_AW-1:0] out_index;

  dense_layer_scheduler #(.MAX_IN(MAX_IN), .MAX_OUT(MAX_OUT), .DATA_W(DATA_W), .FRAC_W(8),
                          .ACC_W(40), .RD_LAT(RD_LAT)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
    .cfg_in_len(cfg_in_len), .cfg_out_len(cfg_out_len), .cfg_relu(cfg_relu),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .feat_addr(feat_addr), .wgt_addr(wgt_addr), .bias_addr(bias_addr), .rd_en(rd_en),
    .feat_rdata(feat_rdata), .wgt_rdata(wgt_rdata), .bias_rdata(bias_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_index(out_index)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [15:0] feat_mem [2**FEAT_AW];
  logic [15:0] wgt_mem  [2**WGT_AW];
  logic [15:0] bias_mem [2**BIAS_AW];
  logic [15:0] fpipe [RD_LAT];
  logic [15:0] wpipe [RD_LAT];
  logic [15:0] bpipe [RD_LAT];

  // Memories with RD_LAT cycles of read latency
  always @(posedge clock) begin
    fpipe[0] <= feat_mem[feat_addr];
    wpipe[0] <= wgt_mem[wgt_addr];
    bpipe[0] <= bias_mem[bias_addr];
    for (int k = 1; k < RD_LAT; k++) begin
      fpipe[k] <= fpipe[k-1];
      wpipe[k] <= wpipe[k-1];
      bpipe[k] <= bpipe[k-1];
    end
  end
  assign feat_rdata = fpipe[RD_LAT-1];
  assign wgt_rdata  = wpipe[RD_LAT-1];
  assign bias_rdata = bpipe[RD_LAT-1];

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    int in_len;
    int out_len;
    bit relu;
    logic [0:3][15:0] feat;
    logic [0:7][15:0] wgt;
    logic [0:1][15:0] bias;
    logic [0:1][15:0] expd;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Dense neuron from first principles: Q8.8 dot product plus bias, floor, clamp, ReLU.
  function automatic logic [15:0] ref_neuron(input int o, input int in_len, input bit relu);
    longint acc, r;
    acc = longint'($signed(bias_mem[o])) * 256;
    for (int i = 0; i < in_len; i++)
      acc += longint'($signed(feat_mem[i])) * longint'($signed(wgt_mem[o*in_len+i]));
    r = acc / 256;
    if ((acc % 256) != 0 && acc < 0) r = r - 1;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    if (relu && r < 0) r = 0;
    return r[15:0];
  endfunction

  function automatic logic [15:0] rand_val(input bit big);
    if (big) return 16'($urandom);
    return 16'(int'($urandom_range(0, 1023)) - 512);
  endfunction

  // mode 0: ready always; 1: random ready; 2: hold ready low 10 cycles per result and poke start
  task automatic run_layer(input int in_len, input int out_len, input bit relu, input int mode);
    int n_out, rd_cnt, lat, cyc, stall, bad_busy, bad_emit_rd, bad_stable, budget;
    bit seen_done;
    logic [15:0] held;
    n_out = 0; rd_cnt = 0; lat = -1; stall = 0; bad_busy = 0; bad_emit_rd = 0;
    bad_stable = 0; seen_done = 0; held = '0;
    budget = 100 + out_len * (in_len + RD_LAT + 40);
    @(negedge clock);
    cfg_in_len = IN_LW'(in_len); cfg_out_len = OUT_LW'(out_len); cfg_relu = relu;
    start = 1'b1; out_ready = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check(rd_en && busy && wgt_addr == 0 && bias_addr == 0, "bias_cycle_wgt_addr",
          longint'(wgt_addr), 0);
    cyc = 0;
    while (!seen_done && cyc < budget) begin
      start = (mode == 2 && cyc == 5);
      if (start) begin
        cfg_in_len = 1; cfg_out_len = 1;
      end
      if (rd_en) rd_cnt++;
      if (out_valid && lat < 0) lat = cyc;
      if (out_valid && rd_en) bad_emit_rd++;
      if (done) begin
        seen_done = 1;
        if (busy) bad_busy++;
      end else if (!busy) bad_busy++;
      if (mode == 1) out_ready = 1'($urandom_range(0, 1));
      else if (mode == 2) begin
        if (stall > 0 && (!out_valid || out_data != held)) bad_stable++;
        if (out_valid && stall < 10) begin
          if (stall == 0) held = out_data;
          stall++;
          out_ready = 1'b0;
        end else out_ready = 1'b1;
      end else out_ready = 1'b1;
      if (out_valid && out_ready) begin
        if (n_out < exp_q.size()) begin
          check(out_data == exp_q[n_out], $sformatf("data[%0d]", n_out), out_data, exp_q[n_out]);
          check(out_index == BIAS_AW'(n_out), $sformatf("index[%0d]", n_out), out_index, n_out);
        end else check(1'b0, "extra_result", n_out, exp_q.size());
        n_out++;
        stall = 0;
      end
      if (!seen_done) begin
        @(negedge clock);
        cyc++;
      end
    end
    start = 1'b0;
    check(seen_done, "done_seen", seen_done, 1);
    check(n_out == out_len, "n_results", n_out, out_len);
    check(rd_cnt == out_len * (in_len + 1), "read_count", rd_cnt, out_len * (in_len + 1));
    check(lat == in_len + RD_LAT + 1, "first_latency", lat, in_len + RD_LAT + 1);
    check(bad_busy == 0, "busy_span", bad_busy, 0);
    check(bad_emit_rd == 0, "no_read_in_emit", bad_emit_rd, 0);
    if (mode == 2) check(bad_stable == 0, "emit_stable", bad_stable, 0);
    @(negedge clock);
    out_ready = 1'b1;
    check(!done && !busy && !out_valid, "done_pulse", {done, busy, out_valid}, 0);
  endtask

  task automatic check_cfg_err(input int in_len, input int out_len, input string name);
    @(negedge clock);
    cfg_in_len = IN_LW'(in_len); cfg_out_len = OUT_LW'(out_len); start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check(cfg_err && !busy, {name, "_pulse"}, {cfg_err, busy}, 2'b10);
    @(negedge clock);
    check(!cfg_err && !busy && !rd_en, {name, "_after"}, {cfg_err, busy, rd_en}, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int in_len, out_len, cnt, bad;
    bit relu, big;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_relu = 1'b0;
    cfg_in_len = '0; cfg_out_len = '0; out_ready = 1'b1;
    repeat (3) @(negedge clock);
    check(!busy && !done && !cfg_err && !rd_en && !out_valid, "reset_ctrl",
          {busy, done, cfg_err, rd_en, out_valid}, 0);
    check(feat_addr == 0 && wgt_addr == 0 && bias_addr == 0, "reset_addr",
          {feat_addr, wgt_addr, bias_addr}, 0);
    check(out_data == 0 && out_index == 0, "reset_out", {out_data, out_index}, 0);
    reset_n = 1'b1;
    @(negedge clock);
    check(!busy && !rd_en && !out_valid, "idle_after_reset", {busy, rd_en, out_valid}, 0);

    vecs[0] = '{3, 2, 1'b0, {16'h0100, 16'h0200, 16'hFF00, 16'h0000},
                {16'h0080, 16'h0080, 16'h0080, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000},
                {16'h0000, 16'hFD00}, {16'h0100, 16'hFE00}};
    vecs[1] = '{3, 2, 1'b1, {16'h0100, 16'h0200, 16'hFF00, 16'h0000},
                {16'h0080, 16'h0080, 16'h0080, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000},
                {16'h0000, 16'hFD00}, {16'h0100, 16'h0000}};
    vecs[2] = '{2, 1, 1'b0, {16'h7F00, 16'h7F00, 16'h0000, 16'h0000},
                {16'h7F00, 16'h7F00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000},
                {16'h0000, 16'h0000}, {16'h7FFF, 16'h0000}};
    vecs[3] = '{2, 1, 1'b0, {16'h7F00, 16'h7F00, 16'h0000, 16'h0000},
                {16'h8100, 16'h8100, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000},
                {16'h0000, 16'h0000}, {16'h8000, 16'h0000}};
    vecs[4] = '{1, 2, 1'b0, {16'h0180, 16'h0000, 16'h0000, 16'h0000},
                {16'h0080, 16'hFF80, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000},
                {16'h0001, 16'h0000}, {16'h00C1, 16'hFF40}};
    vecs[5] = '{1, 1, 1'b0, {16'h0001, 16'h0000, 16'h0000, 16'h0000},
                {16'hFF80, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000},
                {16'h0000, 16'h0000}, {16'hFFFF, 16'h0000}};

    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < 4; k++) feat_mem[k] = vecs[v].feat[k];
      for (int k = 0; k < 8; k++) wgt_mem[k] = vecs[v].wgt[k];
      for (int k = 0; k < 2; k++) bias_mem[k] = vecs[v].bias[k];
      exp_q.delete();
      for (int o = 0; o < vecs[v].out_len; o++) exp_q.push_back(vecs[v].expd[o]);
      run_layer(vecs[v].in_len, vecs[v].out_len, vecs[v].relu, (v == 4) ? 2 : ((v == 1 || v == 5) ? 1 : 0));
    end

    for (int r = 0; r < 8; r++) begin
      in_len  = $urandom_range(1, 24);
      out_len = $urandom_range(1, 5);
      relu    = 1'($urandom_range(0, 1));
      big     = 1'($urandom_range(0, 1));
      for (int i = 0; i < in_len; i++) feat_mem[i] = rand_val(big);
      for (int k = 0; k < in_len * out_len; k++) wgt_mem[k] = rand_val(big);
      for (int o = 0; o < out_len; o++) bias_mem[o] = rand_val(big);
      exp_q.delete();
      for (int o = 0; o < out_len; o++) exp_q.push_back(ref_neuron(o, in_len, relu));
      run_layer(in_len, out_len, relu, $urandom_range(0, 2));
    end

    check_cfg_err(0, 2, "err_in_zero");
    check_cfg_err(3, 0, "err_out_zero");
    check_cfg_err(MAX_IN + 1, 2, "err_in_big");
    check_cfg_err(3, MAX_OUT + 1, "err_out_big");

    @(negedge clock);
    cfg_in_len = 3; cfg_out_len = 2; start = 1'b1; abort = 1'b1;
    @(negedge clock);
    start = 1'b0; abort = 1'b0;
    check(!busy && !cfg_err && !rd_en, "abort_beats_start", {busy, cfg_err, rd_en}, 0);

    for (int i = 0; i < MAX_IN; i++) feat_mem[i] = rand_val(1'b0);
    for (int k = 0; k < MAX_IN * 2; k++) wgt_mem[k] = rand_val(1'b0);
    bias_mem[0] = rand_val(1'b0);
    bias_mem[1] = rand_val(1'b0);
    @(negedge clock);
    cfg_in_len = IN_LW'(MAX_IN); cfg_out_len = 2; cfg_relu = 1'b0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cnt = 0;
    while (!(rd_en && feat_addr == 100) && cnt < 1000) begin
      @(negedge clock);
      cnt++;
    end
    check(cnt < 1000, "reach_i100", cnt, 1000);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check(!busy && !rd_en && !out_valid && !done, "abort_idle", {busy, rd_en, out_valid, done}, 0);
    bad = 0;
    repeat (20) begin
      @(negedge clock);
      if (done || out_valid || busy) bad++;
    end
    check(bad == 0, "abort_quiet", bad, 0);
    exp_q.delete();
    for (int o = 0; o < 2; o++) exp_q.push_back(ref_neuron(o, MAX_IN, 1'b0));
    run_layer(MAX_IN, 2, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
